// File: rtl/eth_mac_cfg_if.sv
// Register write port shared by the configuration sequencer and the MAC
// instances. The sequencer drives address, data and the write strobe; the
// register fabric answers with busy to stall a write.
interface eth_mac_cfg_if #(
    parameter int unsigned ADDR_W = 8
) ();
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       data_out;
    logic              wren;
    logic              busy;

    modport master (
        output reg_addr,
        output data_out,
        output wren,
        input  busy
    );

    modport slave (
        input  reg_addr,
        input  data_out,
        input  wren,
        output busy
    );
endinterface

// File: rtl/eth_mac_cfg.sv
// Power-up configuration sequencer for NUM_PORTS Ethernet MACs sharing one
// register write port. Each port is disabled, given its MAC address
// (MAC_ADDR + port) and max frame length, then re-enabled. A write that stays
// stalled by busy beyond BUSY_TIMEOUT cycles parks the sequencer in ERROR,
// holding the failing write on the bus for inspection.
module eth_mac_cfg #(
    parameter int unsigned NUM_PORTS    = 1,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned PORT_STRIDE  = 'h40,
    parameter logic [47:0] MAC_ADDR     = 48'h001C23174ACB,
    parameter int unsigned FRM_LEN      = 1518,
    parameter bit          PROMISC      = 1'b1,
    parameter bit          PAD_REMOVE   = 1'b1,
    parameter int unsigned BUSY_TIMEOUT = 1024,
    parameter bit          AUTO_START   = 1'b1
) (
    input  logic                 clk_hifreq,
    input  logic                 rst,
    input  logic                 start,
    eth_mac_cfg_if.master        bus,
    output logic [3:0]           cur_port,
    output logic                 done,
    output logic                 error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD_DIS,
        STEP_MAC0,
        STEP_MAC1,
        STEP_FRMLEN,
        STEP_CMD_EN
    } step_t;

    localparam int unsigned     TMO_W     = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(BUSY_TIMEOUT);
    localparam logic [3:0]      LAST_PORT = 4'(NUM_PORTS - 1);

    state_t            state_q, state_d;
    step_t             step_q, step_d;
    logic [3:0]        port_q, port_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              wren_q, wren_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              launch;

    // Register address of a step: per-port base plus the register offset,
    // wrapping at the width of the address bus.
    function automatic logic [ADDR_W-1:0] step_addr(input logic [3:0] port, input step_t step);
        logic [7:0] offset;
        case (step)
            STEP_MAC0:   offset = 8'h03;
            STEP_MAC1:   offset = 8'h04;
            STEP_FRMLEN: offset = 8'h05;
            default:     offset = 8'h02;   // CMD_DIS and CMD_EN share the command register
        endcase
        return ADDR_W'(32'(port) * PORT_STRIDE + 32'(offset));
    endfunction

    // Write data of a step. MAC_ADDR[47:40] is the first octet on the wire,
    // so it lands in the least significant byte of MAC0.
    function automatic logic [31:0] step_data(input logic [3:0] port, input step_t step);
        logic [47:0] mac;
        mac = MAC_ADDR + 48'(port);
        case (step)
            STEP_MAC0:   return {mac[23:16], mac[31:24], mac[39:32], mac[47:40]};
            STEP_MAC1:   return {16'h0, mac[7:0], mac[15:8]};
            STEP_FRMLEN: return 32'(FRM_LEN);
            STEP_CMD_EN: return {26'h0, PAD_REMOVE, PROMISC, 2'b00, 2'b11};
            default:     return 32'h0;
        endcase
    endfunction

    // Next-state logic: walk ports and steps, stall on busy, time out, restart on start.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        step_d  = step_q;
        port_d  = port_q;
        tmo_d   = tmo_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wren_d  = 1'b0;
        done_d  = done_q;
        error_d = error_q;
        launch  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start || AUTO_START) begin
                    launch = 1'b1;
                end
            end

            S_ISSUE: begin
                wren_d = 1'b1;
                if (!bus.busy) begin
                    // Write accepted; step/port advance now so cur_port is
                    // already updated during the following gap cycle.
                    wren_d = 1'b0;
                    if (port_q == LAST_PORT && step_q == STEP_CMD_EN) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        if (step_q == STEP_CMD_EN) begin
                            step_d = STEP_CMD_DIS;
                            port_d = port_q + 4'd1;
                        end else begin
                            step_d = step_t'(3'(step_q) + 3'd1);
                        end
                    end
                end else if (BUSY_TIMEOUT != 0) begin
                    if (tmo_q == TMO_LIMIT) begin
                        wren_d  = 1'b0;
                        state_d = S_ERROR;
                        error_d = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
            end

            S_GAP: begin
                state_d = S_ISSUE;
                wren_d  = 1'b1;
                tmo_d   = '0;
                addr_d  = step_addr(port_q, step_q);
                data_d  = step_data(port_q, step_q);
            end

            S_DONE, S_ERROR: begin
                if (start) begin
                    launch = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (launch) begin
            state_d = S_ISSUE;
            step_d  = STEP_CMD_DIS;
            port_d  = 4'd0;
            tmo_d   = '0;
            wren_d  = 1'b1;
            done_d  = 1'b0;
            error_d = 1'b0;
            addr_d  = step_addr(4'd0, STEP_CMD_DIS);
            data_d  = step_data(4'd0, STEP_CMD_DIS);
        end
    end

    // State and registered outputs; reset clears everything at once, even mid-write.
    always_ff @(posedge clk_hifreq or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            step_q  <= STEP_CMD_DIS;
            port_q  <= 4'd0;
            tmo_q   <= '0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q <= state_d;
            step_q  <= step_d;
            port_q  <= port_d;
            tmo_q   <= tmo_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wren_q  <= wren_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign bus.reg_addr = addr_q;
    assign bus.data_out = data_q;
    assign bus.wren     = wren_q;
    assign cur_port     = port_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_eth_mac_cfg.sv
// Bench for eth_mac_cfg. Two instances with different parameters share one
// clock; sel picks which one the stimulus tasks drive and observe. Expected
// writes come from a list built straight from the register map rules.
module tb_eth_mac_cfg;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    logic sel = 1'b0;
    logic busy_drv = 1'b0;
    logic start_drv = 1'b0;
    logic start_a, start_b;

    logic [3:0] port_a, port_b;
    logic       done_a, done_b, error_a, error_b;

    int n_checks = 0;
    int n_errors = 0;

    int          exp_addr[$];
    logic [31:0] exp_data[$];

    always #5 clk = ~clk;

    eth_mac_cfg_if #(.ADDR_W(8)) bus_a ();
    eth_mac_cfg_if #(.ADDR_W(8)) bus_b ();

    assign bus_a.busy = !sel && busy_drv;
    assign bus_b.busy = sel && busy_drv;
    assign start_a    = !sel && start_drv;
    assign start_b    = sel && start_drv;

    // Instance A: two ports, default address map, short timeout, auto start.
    eth_mac_cfg #(
        .NUM_PORTS(2),
        .BUSY_TIMEOUT(4)
    ) dut_a (
        .clk_hifreq(clk),
        .rst(rst_a),
        .start(start_a),
        .bus(bus_a),
        .cur_port(port_a),
        .done(done_a),
        .error(error_a)
    );

    // Instance B: four ports, stride that wraps the 8-bit address, MAC carry,
    // no timeout, manual start.
    eth_mac_cfg #(
        .NUM_PORTS(4),
        .PORT_STRIDE('h70),
        .MAC_ADDR(48'h0000000000FF),
        .BUSY_TIMEOUT(0),
        .AUTO_START(1'b0)
    ) dut_b (
        .clk_hifreq(clk),
        .rst(rst_b),
        .start(start_b),
        .bus(bus_b),
        .cur_port(port_b),
        .done(done_b),
        .error(error_b)
    );

    logic [7:0]  o_addr;
    logic [31:0] o_data;
    logic        o_wren, o_done, o_error;
    logic [3:0]  o_port;

    assign o_addr  = sel ? bus_b.reg_addr : bus_a.reg_addr;
    assign o_data  = sel ? bus_b.data_out : bus_a.data_out;
    assign o_wren  = sel ? bus_b.wren     : bus_a.wren;
    assign o_port  = sel ? port_b         : port_a;
    assign o_done  = sel ? done_b         : done_a;
    assign o_error = sel ? error_b        : error_a;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected write list: for each port, MAC = base + port (48-bit wrap),
    // octet 0 is the most significant byte of the MAC.
    task automatic build_model(input int np, input int stride, input logic [47:0] base);
        logic [47:0] mac;
        logic [7:0]  o [6];
        int          offs [5] = '{2, 3, 4, 5, 2};
        exp_addr.delete();
        exp_data.delete();
        for (int p = 0; p < np; p++) begin
            mac = base + 48'(p);
            for (int i = 0; i < 6; i++) o[i] = 8'(mac >> (8 * (5 - i)));
            for (int s = 0; s < 5; s++) begin
                exp_addr.push_back((p * stride + offs[s]) % 256);
                case (s)
                    0: exp_data.push_back(32'h0);
                    1: exp_data.push_back({o[3], o[2], o[1], o[0]});
                    2: exp_data.push_back({16'h0, o[5], o[4]});
                    3: exp_data.push_back(32'd1518);
                    default: exp_data.push_back(32'(1 + 2 + 16 + 32));  // TX, RX, PROMISC, PAD
                endcase
            end
        end
    endtask

    task automatic pulse_start();
        start_drv = 1'b1;
        @(negedge clk);
        start_drv = 1'b0;
        check("start_rise_wren", o_wren, 1'b1);
    endtask

    // Entered at a negedge where the first write is already on the bus.
    // Accepts n_writes writes, checking every ISSUE cycle against the list.
    task automatic run_seq(input int n_writes, input bit rand_busy, input int long_at,
                           input int long_len, input bit full);
        int k = 0, t = 0, stall = 0, run = 0, long_cnt = 0, last_acc = 0;
        bit prev_acc = 1'b0;
        while (k < n_writes && t < 2000) begin
            if (prev_acc) check("gap_wren", o_wren, 1'b0);
            prev_acc = 1'b0;
            start_drv = rand_busy && ($urandom_range(0, 7) == 0);  // ignored while busy
            if (o_wren) begin
                check("addr", o_addr, exp_addr[k]);
                check("data", o_data, exp_data[k]);
                check("cur_port", o_port, k / 5);
                if (k == long_at && long_cnt < long_len) begin
                    busy_drv = 1'b1;
                    long_cnt++;
                end else if (rand_busy && run < 3 && $urandom_range(0, 2) == 0) begin
                    busy_drv = 1'b1;
                    run++;
                end else begin
                    busy_drv = 1'b0;
                    run = 0;
                    last_acc = t;
                    prev_acc = 1'b1;
                    k++;
                end
                if (busy_drv) stall++;
            end else begin
                busy_drv = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            @(negedge clk);
            t++;
        end
        busy_drv = 1'b0;
        start_drv = 1'b0;
        check("writes_accepted", k, n_writes);
        if (full) begin
            check("done", o_done, 1'b1);
            check("done_wren", o_wren, 1'b0);
            check("done_error", o_error, 1'b0);
            check("latency", last_acc, 2 * n_writes - 2 + stall);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // ---------------- instance A ----------------
        sel = 1'b0;
        build_model(2, 'h40, 48'h001C23174ACB);
        repeat (2) @(negedge clk);
        check("rst_wren", o_wren, 1'b0);
        check("rst_addr", o_addr, 8'h0);
        check("rst_data", o_data, 32'h0);
        check("rst_port", o_port, 4'h0);
        check("rst_done", o_done, 1'b0);
        check("rst_error", o_error, 1'b0);

        rst_a = 1'b1;
        @(negedge clk);
        check("auto_rise_wren", o_wren, 1'b1);
        run_seq(10, 1'b0, 1, 3, 1'b1);          // MAC0 stalled for 3 cycles

        repeat (3) @(negedge clk);
        check("done_sticky", o_done, 1'b1);
        pulse_start();
        check("restart_clears_done", o_done, 1'b0);
        run_seq(10, 1'b1, -1, 0, 1'b1);

        // Timeout: busy stuck on FRMLEN of port 0
        pulse_start();
        run_seq(3, 1'b0, -1, 0, 1'b0);
        @(negedge clk);
        busy_drv = 1'b1;
        for (int i = 0; i < 20 && !o_error; i++) begin
            check("stall_wren", o_wren, 1'b1);
            check("stall_addr", o_addr, 8'h05);
            @(negedge clk);
        end
        check("tmo_error", o_error, 1'b1);
        check("tmo_wren", o_wren, 1'b0);
        check("tmo_addr", o_addr, 8'h05);
        check("tmo_data", o_data, 32'd1518);
        check("tmo_done", o_done, 1'b0);
        check("tmo_port", o_port, 4'h0);
        repeat (3) @(negedge clk);
        check("tmo_sticky", o_error, 1'b1);
        busy_drv = 1'b0;
        pulse_start();
        check("tmo_restart_addr", o_addr, 8'h02);
        check("tmo_restart_err", o_error, 1'b0);
        run_seq(10, 1'b1, -1, 0, 1'b1);

        // Reset in the middle of the port-0 MAC1 write
        pulse_start();
        run_seq(2, 1'b0, -1, 0, 1'b0);
        @(negedge clk);
        check("pre_rst_addr", o_addr, 8'h04);
        busy_drv = 1'b1;
        #2 rst_a = 1'b0;
        #1;
        check("midrst_wren", o_wren, 1'b0);
        check("midrst_addr", o_addr, 8'h0);
        check("midrst_data", o_data, 32'h0);
        check("midrst_port", o_port, 4'h0);
        check("midrst_done", o_done, 1'b0);
        check("midrst_error", o_error, 1'b0);
        @(negedge clk);
        busy_drv = 1'b0;
        rst_a = 1'b1;
        @(negedge clk);
        check("rst_restart_wren", o_wren, 1'b1);
        check("rst_restart_addr", o_addr, 8'h02);
        run_seq(10, 1'b1, -1, 0, 1'b1);

        // ---------------- instance B ----------------
        sel = 1'b1;
        build_model(4, 'h70, 48'h0000000000FF);
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_idle_wren", o_wren, 1'b0);
        end
        check("b_idle_done", o_done, 1'b0);
        pulse_start();
        run_seq(20, 1'b1, 7, 40, 1'b1);           // 40-cycle stall with timeout disabled
        pulse_start();
        run_seq(20, 1'b1, -1, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
